// File: rtl/tinyalu_stim_gen_if.sv
// Operand/op/handshake bundle between the stimulus generator (master) and the TinyALU (slave).
// Purely a wiring container; it holds no state.
interface tinyalu_stim_gen_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [2:0]        op;
  logic              start;
  logic              done;
  logic              alu_reset_n;

  modport master (
    output A,
    output B,
    output op,
    output start,
    output alu_reset_n,
    input  done
  );

  modport slave (
    input  A,
    input  B,
    input  op,
    input  start,
    input  alu_reset_n,
    output done
  );
endinterface

// File: rtl/tinyalu_stim_gen.sv
// LFSR-driven TinyALU op generator: registers op/A/B in GEN, drives start from the next cycle,
// waits on done (aborting after TIMEOUT cycles) and runs a programmed number of operations.
module tinyalu_stim_gen #(
  parameter int DATA_W     = 8,
  parameter int LFSR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_go,
  input  logic [LFSR_W-1:0]  cfg_seed,
  input  logic [CNT_W-1:0]   cfg_num_ops,
  input  logic [1:0]         cfg_mode,
  input  logic [2:0]         cfg_op,
  tinyalu_stim_gen_if.master alu,
  output logic               busy,
  output logic               finished,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   ops_issued
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_ISSUE,
    S_NOOP,
    S_RST,
    S_GAP,
    S_FIN
  } state_t;

  localparam logic [2:0]        OP_NOOP     = 3'b000;
  localparam logic [2:0]        OP_RST      = 3'b111;
  localparam logic [LFSR_W-1:0] LP_TAPS     = LFSR_W'(32'h8020_0003);
  localparam int                LP_WAIT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int                LP_WAIT_W   = $clog2(LP_WAIT_MAX + 1);
  localparam logic [LP_WAIT_W-1:0] LP_TO_LAST  = LP_WAIT_W'(TIMEOUT - 1);
  localparam logic [LP_WAIT_W-1:0] LP_RST_LAST = LP_WAIT_W'(RST_CYCLES - 1);

  state_t               r_state, w_state_nxt;
  logic [LFSR_W-1:0]    r_lfsr, w_lfsr_nxt, w_lfsr_step;
  logic [CNT_W-1:0]     r_num_ops;
  logic [1:0]           r_mode;
  logic [2:0]           r_cfg_op;
  logic [DATA_W-1:0]    r_a, r_b, w_a_nxt, w_b_nxt, w_a_dec, w_b_dec;
  logic [2:0]           r_op, w_op_nxt, w_op_dec;
  logic                 r_start, r_alu_rst_n;
  logic                 r_busy, w_busy_nxt;
  logic                 r_finished, w_finished_nxt;
  logic                 r_timeout, w_timeout_nxt;
  logic [CNT_W-1:0]     r_count, w_count_nxt, w_count_inc;
  logic [LP_WAIT_W-1:0] r_wait, w_wait_nxt;
  logic                 w_load;

  function automatic logic [2:0] f_decode_op(input logic [2:0] code, input logic [1:0] mode,
                                             input logic [2:0] fixed);
    logic [2:0] c;
    logic [2:0] o;
    c = (mode == 2'b01) ? fixed : code;
    case (c)
      3'b001, 3'b010, 3'b011, 3'b100: o = c;
      3'b110, 3'b111:                 o = OP_RST;
      default:                        o = OP_NOOP;
    endcase
    if (mode == 2'b10 && o == OP_RST) o = OP_NOOP;
    return o;
  endfunction

  // Two of the four selector codes force a corner value, giving ~25% zeros and ~25% all-ones.
  function automatic logic [DATA_W-1:0] f_operand(input logic [1:0] sel, input logic [DATA_W-1:0] raw);
    logic [DATA_W-1:0] v;
    case (sel)
      2'b00:   v = '0;
      2'b11:   v = '1;
      default: v = raw;
    endcase
    return v;
  endfunction

  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ LP_TAPS) : (r_lfsr >> 1);
  assign w_op_dec    = f_decode_op(w_lfsr_step[2:0], r_mode, r_cfg_op);
  assign w_a_dec     = f_operand(w_lfsr_step[4:3], w_lfsr_step[8 +: DATA_W]);
  assign w_b_dec     = f_operand(w_lfsr_step[6:5], w_lfsr_step[8 + DATA_W +: DATA_W]);
  assign w_count_inc = (r_count == {CNT_W{1'b1}}) ? r_count : r_count + 1'b1;

  always_comb begin
    w_state_nxt    = r_state;
    w_lfsr_nxt     = r_lfsr;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_op_nxt       = r_op;
    w_busy_nxt     = r_busy;
    w_finished_nxt = 1'b0;
    w_timeout_nxt  = r_timeout;
    w_count_nxt    = r_count;
    w_wait_nxt     = r_wait;
    w_load         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_go) begin
          w_load        = 1'b1;
          w_lfsr_nxt    = (cfg_seed == '0) ? LFSR_W'(1) : cfg_seed;
          w_count_nxt   = '0;
          w_timeout_nxt = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_GEN;
        end
      end
      S_GEN: begin
        w_wait_nxt = '0;
        if (r_count == r_num_ops) begin
          w_state_nxt = S_FIN;
        end else begin
          w_lfsr_nxt = w_lfsr_step;
          w_op_nxt   = w_op_dec;
          w_a_nxt    = w_a_dec;
          w_b_nxt    = w_b_dec;
          case (w_op_dec)
            OP_NOOP: w_state_nxt = S_NOOP;
            OP_RST:  w_state_nxt = S_RST;
            default: w_state_nxt = S_ISSUE;
          endcase
        end
      end
      S_ISSUE: begin
        if (alu.done) begin
          w_count_nxt = w_count_inc;
          w_state_nxt = S_GAP;
        end else if (r_wait == LP_TO_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_FIN;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_NOOP: begin
        w_count_nxt = w_count_inc;
        w_state_nxt = S_GAP;
      end
      S_RST: begin
        if (r_wait == LP_RST_LAST) begin
          w_count_nxt = w_count_inc;
          w_state_nxt = S_GAP;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      S_GAP: w_state_nxt = S_GEN;
      S_FIN: begin
        w_finished_nxt = 1'b1;
        w_busy_nxt     = 1'b0;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // start and alu_reset_n are decoded from the next state so they are glitch-free flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= LFSR_W'(1);
      r_num_ops   <= '0;
      r_mode      <= 2'b00;
      r_cfg_op    <= 3'b000;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 3'b000;
      r_start     <= 1'b0;
      r_alu_rst_n <= 1'b1;
      r_busy      <= 1'b0;
      r_finished  <= 1'b0;
      r_timeout   <= 1'b0;
      r_count     <= '0;
      r_wait      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_op        <= w_op_nxt;
      r_start     <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_NOOP);
      r_alu_rst_n <= (w_state_nxt != S_RST);
      r_busy      <= w_busy_nxt;
      r_finished  <= w_finished_nxt;
      r_timeout   <= w_timeout_nxt;
      r_count     <= w_count_nxt;
      r_wait      <= w_wait_nxt;
      if (w_load) begin
        r_num_ops <= cfg_num_ops;
        r_mode    <= cfg_mode;
        r_cfg_op  <= cfg_op;
      end
    end
  end

  assign alu.A           = r_a;
  assign alu.B           = r_b;
  assign alu.op          = r_op;
  assign alu.start       = r_start;
  assign alu.alu_reset_n = r_alu_rst_n;
  assign busy            = r_busy;
  assign finished        = r_finished;
  assign timeout_err     = r_timeout;
  assign ops_issued      = r_count;

endmodule

// File: tb/tb_tinyalu_stim_gen.sv
// Bench for tinyalu_stim_gen: a TinyALU done responder, a bus monitor and a reference
// sequence model built from the LFSR polynomial and decode table.
module tb_tinyalu_stim_gen;
  localparam int DATA_W = 8;
  localparam int LFSR_W = 32;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              reset_n;
  logic              cfg_go;
  logic [LFSR_W-1:0] cfg_seed;
  logic [CNT_W-1:0]  cfg_num_ops;
  logic [1:0]        cfg_mode;
  logic [2:0]        cfg_op;
  logic              busy, finished, timeout_err;
  logic [CNT_W-1:0]  ops_issued;

  tinyalu_stim_gen_if #(.DATA_W(DATA_W)) alu_bus ();

  tinyalu_stim_gen #(
    .DATA_W(DATA_W), .LFSR_W(LFSR_W), .CNT_W(CNT_W), .RST_CYCLES(2), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_go(cfg_go), .cfg_seed(cfg_seed),
    .cfg_num_ops(cfg_num_ops), .cfg_mode(cfg_mode), .cfg_op(cfg_op), .alu(alu_bus),
    .busy(busy), .finished(finished), .timeout_err(timeout_err), .ops_issued(ops_issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit alu_en = 1'b1;
  bit alu_rand = 1'b0;
  int obs_op[$], obs_a[$], obs_b[$], gap_q[$];
  int start_hi = 0, rst_lo = 0, rst_falls = 0, fin_cnt = 0, ended_by_done = 0;
  int op_map[8] = '{0, 1, 2, 3, 4, 0, 7, 7};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ALU stand-in: raises done for one cycle, cur_dly cycles after start for real ops.
  initial begin : responder
    int cnt;
    int cur_dly;
    cnt = 0;
    cur_dly = 2;
    alu_bus.done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (alu_bus.done) begin
        alu_bus.done = 1'b0;
        cnt = 0;
        cur_dly = alu_rand ? int'($urandom_range(1, 3)) : 2;
      end else if (alu_en && alu_bus.start === 1'b1 && alu_bus.op inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
        cnt++;
        if (cnt >= cur_dly) alu_bus.done = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : monitor
    bit p_start, p_rst, p_done, seen;
    int low_run;
    p_start = 0; p_rst = 1; p_done = 0; seen = 0; low_run = 0;
    forever begin
      @(negedge clk);
      if (alu_bus.start === 1'b1 && !p_start) begin
        obs_op.push_back(int'(alu_bus.op)); obs_a.push_back(int'(alu_bus.A)); obs_b.push_back(int'(alu_bus.B));
        if (seen) gap_q.push_back(low_run);
        seen = 1;
      end
      if (alu_bus.start !== 1'b1 && p_start && p_done) ended_by_done++;
      if (alu_bus.alu_reset_n === 1'b0 && p_rst) begin
        obs_op.push_back(int'(alu_bus.op)); obs_a.push_back(int'(alu_bus.A)); obs_b.push_back(int'(alu_bus.B));
        rst_falls++;
      end
      if (alu_bus.start === 1'b1) begin start_hi++; low_run = 0; end
      else low_run++;
      if (alu_bus.alu_reset_n === 1'b0) rst_lo++;
      if (finished === 1'b1) fin_cnt++;
      p_start = (alu_bus.start === 1'b1);
      p_rst   = (alu_bus.alu_reset_n !== 1'b0);
      p_done  = (alu_bus.done === 1'b1);
    end
  end

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    return (s / 2) ^ ((s % 2 == 1) ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic int pick(input int sel, input int raw);
    if (sel == 0) return 0;
    if (sel == 3) return (1 << DATA_W) - 1;
    return raw;
  endfunction

  task automatic compare_seq(input logic [31:0] seed, input int n, input int mode, input int opc, input int base);
    logic [31:0] s;
    int op_e, a_e, b_e;
    s = (seed == 0) ? 32'd1 : seed;
    check_eq("obs_count", obs_op.size() - base, n);
    for (int i = 0; i < n; i++) begin
      s = ref_next(s);
      op_e = (mode == 1) ? op_map[opc] : op_map[s % 8];
      if (mode == 2 && op_e == 7) op_e = 0;
      a_e = pick((s >> 3) % 4, (s >> 8) % (1 << DATA_W));
      b_e = pick((s >> 5) % 4, (s >> (8 + DATA_W)) % (1 << DATA_W));
      if (base + i < obs_op.size()) begin
        check_eq($sformatf("op[%0d]", i), obs_op[base+i], op_e);
        check_eq($sformatf("A[%0d]", i), obs_a[base+i], a_e);
        check_eq($sformatf("B[%0d]", i), obs_b[base+i], b_e);
      end
    end
  endtask

  task automatic run(input logic [31:0] seed, input int n, input logic [1:0] mode, input logic [2:0] opc,
                     input int budget, input bit rego, output int cyc);
    int c;
    @(negedge clk);
    cfg_seed = seed; cfg_num_ops = CNT_W'(n); cfg_mode = mode; cfg_op = opc; cfg_go = 1'b1;
    for (c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) cfg_go = 1'b0;
      if (rego && c == 20) begin cfg_go = 1'b1; cfg_num_ops = 16'd9; end
      if (rego && c == 21) cfg_go = 1'b0;
      if (finished === 1'b1) break;
    end
    cyc = c;
    if (c > budget) check_eq("run_finish_wait", 0, 1);
  endtask

  initial begin : main
    int cyc, base, s_hi, s_lo, s_rf, s_fin, s_end, s_gap, bad, zero_a, ones_a;
    int seen[8];
    logic [31:0] rseed;
    reset_n = 1'b1; cfg_go = 0; cfg_seed = '0; cfg_num_ops = '0; cfg_mode = 0; cfg_op = 0;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_start", alu_bus.start, 0);
    check_eq("rst_alu_reset_n", alu_bus.alu_reset_n, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_finished", finished, 0);
    check_eq("rst_timeout", timeout_err, 0);
    check_eq("rst_ops", ops_issued, 0);
    check_eq("rst_opAB", {alu_bus.op, alu_bus.A, alu_bus.B}, 0);
    reset_n = 1'b1;

    // zero operations
    s_hi = start_hi; s_fin = fin_cnt;
    run(32'h5, 0, 2'b00, 3'b000, 20, 0, cyc);
    check_eq("t1_fin_cycle", cyc, 3);
    check_eq("t1_start_hi", start_hi - s_hi, 0);
    check_eq("t1_ops", ops_issued, 0);
    @(negedge clk);
    check_eq("t1_fin_pulses", fin_cnt - s_fin, 1);
    check_eq("t1_busy", busy, 0);

    // fixed add, done two cycles after start
    base = obs_op.size(); s_end = ended_by_done; s_gap = gap_q.size(); s_fin = fin_cnt;
    run(32'h1234, 4, 2'b01, 3'b001, 200, 0, cyc);
    @(negedge clk);
    compare_seq(32'h1234, 4, 1, 1, base);
    check_eq("t2_ended_by_done", ended_by_done - s_end, 4);
    bad = 0;
    for (int i = s_gap; i < gap_q.size(); i++) if (gap_q[i] < 1) bad++;
    check_eq("t2_gap_low", bad, 0);
    check_eq("t2_ops", ops_issued, 4);
    check_eq("t2_fin_pulses", fin_cnt - s_fin, 1);

    // done never arrives; a second cfg_go mid-run must be ignored
    alu_en = 1'b0;
    s_hi = start_hi; s_fin = fin_cnt;
    run(32'h77, 1, 2'b01, 3'b001, 300, 1, cyc);
    @(negedge clk);
    check_eq("t4_start_hi", start_hi - s_hi, 64);
    check_eq("t4_timeout_err", timeout_err, 1);
    check_eq("t4_ops", ops_issued, 0);
    check_eq("t4_fin_pulses", fin_cnt - s_fin, 1);
    check_eq("t4_busy", busy, 0);
    alu_en = 1'b1;

    // fixed rst op
    base = obs_op.size(); s_hi = start_hi; s_lo = rst_lo; s_rf = rst_falls;
    run(32'h99, 2, 2'b01, 3'b111, 100, 0, cyc);
    check_eq("t5_rst_lo", rst_lo - s_lo, 4);
    check_eq("t5_rst_falls", rst_falls - s_rf, 2);
    check_eq("t5_start_hi", start_hi - s_hi, 0);
    check_eq("t5_ops", ops_issued, 2);
    check_eq("t5_timeout_cleared", timeout_err, 0);
    compare_seq(32'h99, 2, 1, 7, base);

    // long random run against the reference sequence
    alu_rand = 1'b1;
    base = obs_op.size();
    run(32'hACE1, 1000, 2'b00, 3'b000, 20000, 0, cyc);
    compare_seq(32'hACE1, 1000, 0, 0, base);
    check_eq("t3_ops", ops_issued, 1000);
    zero_a = 0; ones_a = 0;
    for (int k = 0; k < 8; k++) seen[k] = 0;
    for (int i = base; i < obs_op.size(); i++) begin
      seen[obs_op[i] % 8]++;
      if (obs_a[i] == 0) zero_a++;
      if (obs_a[i] == (1 << DATA_W) - 1) ones_a++;
    end
    foreach (seen[k]) if (k <= 4 || k == 7) check_eq($sformatf("t3_op%0d_seen", k), seen[k] > 0, 1);
    check_eq("t3_a_zero_share", zero_a >= 180 && zero_a <= 320, 1);
    check_eq("t3_a_ones_share", ones_a >= 180 && ones_a <= 320, 1);

    // seed 0 behaves as seed 1
    base = obs_op.size();
    run(32'h0, 6, 2'b00, 3'b000, 200, 0, cyc);
    compare_seq(32'h1, 6, 0, 0, base);

    // random seed, no rst ops allowed
    rseed = $urandom;
    base = obs_op.size(); s_rf = rst_falls;
    run(rseed, 200, 2'b10, 3'b000, 5000, 0, cyc);
    compare_seq(rseed, 200, 2, 0, base);
    check_eq("m10_rst_falls", rst_falls - s_rf, 0);

    // asynchronous reset while waiting in ISSUE
    alu_en = 1'b0;
    @(negedge clk);
    cfg_seed = 32'h42; cfg_num_ops = 16'd3; cfg_mode = 2'b01; cfg_op = 3'b001; cfg_go = 1'b1;
    @(negedge clk);
    cfg_go = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("t6_start_before", alu_bus.start, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_start", alu_bus.start, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_alu_reset_n", alu_bus.alu_reset_n, 1);
    check_eq("t6_ops", ops_issued, 0);
    @(negedge clk);
    reset_n = 1'b1;
    alu_en = 1'b1;
    rseed = $urandom;
    base = obs_op.size();
    run(rseed, 50, 2'b00, 3'b000, 2000, 0, cyc);
    compare_seq(rseed, 50, 0, 0, base);
    check_eq("t6_clean_ops", ops_issued, 50);
    check_eq("t6_clean_timeout", timeout_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
